// File: rtl/fetch_ctrl_pkg.sv
// Shared pipeline types for the fetch stage.
//   hazard_data_t : decode-stage hazard/redirect bundle fed back to fetch
//   instfunc_t    : decoded instruction class
//   instr_fetch_t : fetch-advance control (INSTR_MAINTAIN holds the fetch pc)
//   fetch_state_t : fetch FSM states
//   PCINIT_DEFAULT: default fetch address after reset
package pipes;

   typedef enum logic [3:0] {
      ALU, LOAD, STORE, JAL, JALR_P,
      BEQ, BNE, BLT, BGE, BLTU, BGEU
   } instfunc_t;

   typedef enum logic [1:0] {
      INSTR_NEXT     = 2'd0,
      INSTR_MAINTAIN = 2'd1
   } instr_fetch_t;

   typedef struct packed {
      logic [63:0]  pc_out;
      logic [63:0]  offset_out;
      instfunc_t    instfunc;
      logic         ireq_valid;
      instr_fetch_t instr_FETCH;
      logic         reset_IF_ID;
   } hazard_data_t;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_t;

   localparam logic [63:0] PCINIT_DEFAULT = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-bus handshake between fetch (master) and memory (slave).
//   ireq_valid/ireq_addr       : request from fetch
//   iresp_addr_ok              : request accepted this cycle
//   iresp_data_ok/iresp_data   : instruction word returned this cycle
interface fetch_ctrl_if;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_addr_ok;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;

   modport master (
      output ireq_valid, ireq_addr,
      input  iresp_addr_ok, iresp_data_ok, iresp_data
   );

   modport slave (
      input  ireq_valid, ireq_addr,
      output iresp_addr_ok, iresp_data_ok, iresp_data
   );
endinterface

// File: rtl/fetch_ctrl_pc_select.sv
// Combinational redirect detection and target computation.
//   hvalid     : decode bundle carries a live instruction
//   instfunc   : decoded instruction class
//   pc_out     : pc of the decode-stage instruction
//   offset_out : offset (absolute target for JALR_P)
//   br_taken   : resolved branch condition
//   redirect   : fetch must restart at target
//   target     : redirect address (wraps modulo 2^64)
module pc_select
   import pipes::*;
(
   input  logic        hvalid,
   input  instfunc_t   instfunc,
   input  logic [63:0] pc_out,
   input  logic [63:0] offset_out,
   input  logic        br_taken,
   output logic        redirect,
   output logic [63:0] target
);

   always_comb begin
      redirect = 1'b0;
      target   = pc_out + offset_out;
      case (instfunc)
         JAL:    redirect = hvalid;
         JALR_P: begin
            redirect = hvalid;
            target   = offset_out;
         end
         BEQ, BNE, BLT, BGE, BLTU, BGEU: redirect = hvalid & br_taken;
         default: redirect = 1'b0;
      endcase
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one instruction-bus request at a
// time, buffers the returned word for IF/ID and follows decode redirects.
//   clk, reset : clock, synchronous active-low reset
//   dataH      : decode hazard/redirect bundle
//   br_taken   : branch condition for the decode-stage instruction
//   ibus       : instruction-bus master port
//   if_valid, if_instr, if_pc : fetched instruction presented to IF/ID
module fetch_ctrl
   import pipes::*;
#(
   parameter logic [63:0] PCINIT = PCINIT_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  hazard_data_t    dataH,
   input  logic            br_taken,
   fetch_ctrl_if.master    ibus,
   output logic            if_valid,
   output logic [31:0]     if_instr,
   output logic [63:0]     if_pc
);

   fetch_state_t state;
   logic [63:0]  pc;
   logic         squash;
   logic         hold_valid;
   logic [63:0]  buf_pc;
   logic [31:0]  buf_instr;
   logic         redirect;
   logic [63:0]  target;
   logic         stall;
   logic         unused_reset_if_id;

   assign unused_reset_if_id = dataH.reset_IF_ID;

   pc_select u_pc_select (
      .hvalid     (dataH.ireq_valid),
      .instfunc   (dataH.instfunc),
      .pc_out     (dataH.pc_out),
      .offset_out (dataH.offset_out),
      .br_taken   (br_taken),
      .redirect   (redirect),
      .target     (target)
   );

   assign stall = (dataH.instr_FETCH == INSTR_MAINTAIN) && !redirect;

   // A redirect in S_REQ withdraws the request so the stale pc is never issued.
   assign ibus.ireq_valid = reset && (state == S_REQ) && !redirect;
   assign ibus.ireq_addr  = pc;
   assign if_valid        = reset && hold_valid;
   assign if_instr        = buf_instr;
   assign if_pc           = buf_pc;

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc         <= PCINIT;
         state      <= S_REQ;
         squash     <= 1'b0;
         hold_valid <= 1'b0;
         buf_pc     <= '0;
         buf_instr  <= '0;
      end else begin
         case (state)
            S_REQ: begin
               if (redirect)
                  pc <= target;
               else if (ibus.iresp_addr_ok)
                  state <= S_WAIT;
            end
            S_WAIT: begin
               if (ibus.iresp_data_ok) begin
                  // Data for a squashed or just-redirected request is dropped;
                  // the pc already (or now) holds the redirect target.
                  squash <= 1'b0;
                  if (redirect) begin
                     pc    <= target;
                     state <= S_REQ;
                  end else if (squash) begin
                     state <= S_REQ;
                  end else begin
                     buf_pc     <= pc;
                     buf_instr  <= ibus.iresp_data;
                     hold_valid <= 1'b1;
                     state      <= S_HOLD;
                  end
               end else if (redirect) begin
                  pc     <= target;
                  squash <= 1'b1;
               end
            end
            S_HOLD: begin
               if (redirect) begin
                  pc         <= target;
                  hold_valid <= 1'b0;
                  state      <= S_REQ;
               end else if (!stall) begin
                  pc         <= pc + 64'd4;
                  hold_valid <= 1'b0;
                  state      <= S_REQ;
               end
            end
            default: begin
               hold_valid <= 1'b0;
               state      <= S_REQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
   import pipes::*;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } fetch_t;

   logic         clk = 1'b0;
   logic         reset;
   hazard_data_t dataH;
   logic         br_taken;
   logic         if_valid;
   logic [31:0]  if_instr;
   logic [63:0]  if_pc;

   fetch_ctrl_if ibus ();

   fetch_ctrl #(.PCINIT(64'h0000_0000_8000_0000)) dut (
      .clk      (clk),
      .reset    (reset),
      .dataH    (dataH),
      .br_taken (br_taken),
      .ibus     (ibus.master),
      .if_valid (if_valid),
      .if_instr (if_instr),
      .if_pc    (if_pc)
   );

   always #5 clk = ~clk;

   int unsigned compared = 0;
   int unsigned mism     = 0;
   fetch_t      exp_q[$];
   logic [63:0] mpc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_h();
      dataH.pc_out      = '0;
      dataH.offset_out  = '0;
      dataH.instfunc    = ALU;
      dataH.ireq_valid  = 1'b0;
      dataH.instr_FETCH = INSTR_NEXT;
      dataH.reset_IF_ID = 1'b0;
      br_taken          = 1'b0;
   endtask

   task automatic redir(input instfunc_t f, input logic [63:0] pco, input logic [63:0] off, input logic bt);
      dataH.instfunc   = f;
      dataH.pc_out     = pco;
      dataH.offset_out = off;
      dataH.ireq_valid = 1'b1;
      br_taken         = bt;
   endtask

   // Waits (bounded) for if_valid, then pops the scoreboard and compares.
   task automatic pop_check(input string tag);
      fetch_t e;
      int n = 0;
      while (!if_valid && n < 8) begin
         tick(); #1; n++;
      end
      chk({tag, "_valid"}, {63'd0, if_valid}, 64'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_queue_nonempty"}, 64'd0, 64'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_pc"}, if_pc, e.pc);
         chk({tag, "_instr"}, {32'd0, if_instr}, {32'd0, e.instr});
      end
   endtask

   // From S_REQ at a negedge: request at mpc, one-cycle data, ends in S_HOLD.
   task automatic fetch_one(input string tag, input logic [31:0] word);
      ibus.iresp_addr_ok = 1'b1;
      #1;
      chk({tag, "_req_valid"}, {63'd0, ibus.ireq_valid}, 64'd1);
      chk({tag, "_req_addr"}, ibus.ireq_addr, mpc);
      tick();
      ibus.iresp_addr_ok = 1'b0;
      ibus.iresp_data_ok = 1'b1;
      ibus.iresp_data    = word;
      exp_q.push_back('{pc: mpc, instr: word});
      #1;
      chk({tag, "_wait_ifv"}, {63'd0, if_valid}, 64'd0);
      tick();
      ibus.iresp_data_ok = 1'b0;
      #1;
      pop_check(tag);
   endtask

   initial begin
      reset = 1'b0;
      clear_h();
      ibus.iresp_addr_ok = 1'b0;
      ibus.iresp_data_ok = 1'b0;
      ibus.iresp_data    = '0;
      #1;
      chk("rst_ifv", {63'd0, if_valid}, 64'd0);
      chk("rst_reqv", {63'd0, ibus.ireq_valid}, 64'd0);
      tick(); tick();
      chk("rst_addr", ibus.ireq_addr, 64'h8000_0000);
      reset = 1'b1;
      mpc   = 64'h8000_0000;

      // Basic fetch with best-case latency
      fetch_one("first", 32'h0000_0013);

      // Stall while holding
      dataH.instr_FETCH = INSTR_MAINTAIN;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_ifv", {63'd0, if_valid}, 64'd1);
         chk("stall_pc", if_pc, 64'h8000_0000);
         chk("stall_instr", {32'd0, if_instr}, 64'h13);
         chk("stall_reqv", {63'd0, ibus.ireq_valid}, 64'd0);
         tick();
      end
      dataH.instr_FETCH = INSTR_NEXT;
      #1;
      chk("stall_end_ifv", {63'd0, if_valid}, 64'd1);
      tick(); #1;
      chk("adv_ifv", {63'd0, if_valid}, 64'd0);
      chk("adv_addr", ibus.ireq_addr, 64'h8000_0004);
      mpc = 64'h8000_0004;

      // BNE not taken: no redirect
      redir(BNE, 64'h8000_0004, 64'h100, 1'b0);
      #1;
      chk("bne_nt_reqv", {63'd0, ibus.ireq_valid}, 64'd1);
      clear_h();
      tick();
      fetch_one("seq", 32'h0010_0093);
      tick(); #1;
      mpc = 64'h8000_0008;
      chk("seq_addr", ibus.ireq_addr, mpc);

      // BNE taken with negative offset
      redir(BNE, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
      #1;
      chk("bne_t_reqv", {63'd0, ibus.ireq_valid}, 64'd0);
      tick(); clear_h(); #1;
      chk("bne_t_addr", ibus.ireq_addr, 64'h8000_0000);
      chk("bne_t_reqv2", {63'd0, ibus.ireq_valid}, 64'd1);

      // JALR_P absolute target, request suppressed this cycle
      redir(JALR_P, 64'h8000_0000, 64'h8000_0100, 1'b0);
      #1;
      chk("jalr_reqv", {63'd0, ibus.ireq_valid}, 64'd0);
      tick(); clear_h(); #1;
      chk("jalr_addr", ibus.ireq_addr, 64'h8000_0100);
      mpc = 64'h8000_0100;

      // JAL while waiting: squash in-flight data
      ibus.iresp_addr_ok = 1'b1;
      tick();
      ibus.iresp_addr_ok = 1'b0;
      redir(JAL, 64'h8000_0010, 64'h20, 1'b0);
      tick(); clear_h();
      ibus.iresp_data_ok = 1'b1;
      ibus.iresp_data    = 32'hDEAD_BEEF;
      #1;
      chk("sq_wait_reqv", {63'd0, ibus.ireq_valid}, 64'd0);
      tick();
      ibus.iresp_data_ok = 1'b0;
      #1;
      chk("sq_ifv", {63'd0, if_valid}, 64'd0);
      chk("sq_reqv", {63'd0, ibus.ireq_valid}, 64'd1);
      chk("sq_addr", ibus.ireq_addr, 64'h8000_0030);
      mpc = 64'h8000_0030;
      fetch_one("post_sq", 32'h0000_0073);

      // Redirect from S_HOLD drops the buffer
      redir(JAL, 64'h8000_0030, 64'h40, 1'b0);
      #1;
      chk("hold_rd_ifv", {63'd0, if_valid}, 64'd1);
      tick(); clear_h(); #1;
      chk("hold_rd_ifv2", {63'd0, if_valid}, 64'd0);
      chk("hold_rd_addr", ibus.ireq_addr, 64'h8000_0070);

      // Target wraps modulo 2^64
      redir(JAL, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1'b0);
      tick(); clear_h(); #1;
      chk("wrap_addr", ibus.ireq_addr, 64'h10);
      mpc = 64'h10;

      // Reset in S_WAIT; late data_ok after release ignored
      ibus.iresp_addr_ok = 1'b1;
      tick();
      ibus.iresp_addr_ok = 1'b0;
      reset = 1'b0;
      #1;
      chk("rw_reqv", {63'd0, ibus.ireq_valid}, 64'd0);
      tick();
      reset = 1'b1;
      ibus.iresp_data_ok = 1'b1;
      ibus.iresp_data    = 32'hBAD0_BAD0;
      #1;
      chk("rw_addr", ibus.ireq_addr, 64'h8000_0000);
      chk("rw_reqv2", {63'd0, ibus.ireq_valid}, 64'd1);
      tick();
      ibus.iresp_data_ok = 1'b0;
      #1;
      chk("rw_ifv", {63'd0, if_valid}, 64'd0);
      chk("rw_addr2", ibus.ireq_addr, 64'h8000_0000);
      mpc = 64'h8000_0000;
      fetch_one("after_rst", 32'h0020_0113);

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end

endmodule
